// File: rtl/elastic_pipe_chain_if.sv
// Valid/ready/data stream bundle used on both sides of the pipeline chain.
// master drives valid/data, slave answers with ready.
interface elastic_pipe_chain_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/elastic_pipe_chain.sv
// N-stage elastic register chain: valid/ready handshake, bubble collapse,
// freeze, partial flush of the youngest stages, occupancy and kill counters.

module epc_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_d,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_q,
    output logic [DATA_WIDTH-1:0] data_q
);
    logic [DATA_WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) data_d = data_in;
    end

    // Data is reset too so out_data never shows X after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

module elastic_pipe_chain #(
    parameter int DATA_WIDTH   = 32,
    parameter int STAGES       = 4,
    parameter int FLUSH_STAGES = 2,
    parameter int CNT_WIDTH    = 16,
    localparam int OCC_W       = $clog2(STAGES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    elastic_pipe_chain_if.slave         up,
    elastic_pipe_chain_if.master        dn,
    input  logic                        freeze,
    input  logic                        flush,
    output logic [OCC_W-1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]        flush_count
);
    localparam logic FLUSH_ALL = (FLUSH_STAGES == STAGES);

    logic [STAGES-1:0]                 valid_q;
    logic [STAGES-1:0]                 valid_d;
    logic [STAGES-1:0]                 adv;
    logic [STAGES-1:0]                 load;
    logic [STAGES-1:0][DATA_WIDTH-1:0] data_q;
    logic [STAGES-1:0][DATA_WIDTH-1:0] src_data;
    logic                              in_xfer;
    logic                              out_xfer;
    logic                              all_above;
    logic [OCC_W-1:0]                  occupancy_q;
    logic [OCC_W-1:0]                  occupancy_d;
    logic [OCC_W-1:0]                  killed;
    logic [CNT_WIDTH-1:0]              flush_count_q;
    logic [CNT_WIDTH-1:0]              flush_count_d;
    logic [CNT_WIDTH:0]                cnt_sum;

    // Handshake and advance. adv[i] is written in closed form: a stage moves
    // when some younger-than-output stage above it is empty or the head leaves.
    always_comb begin
        dn.valid  = valid_q[STAGES-1] & ~freeze & ~(flush & FLUSH_ALL);
        dn.data   = data_q[STAGES-1];
        out_xfer  = dn.valid & dn.ready;
        adv       = '0;
        adv[STAGES-1] = out_xfer;
        all_above = 1'b1;
        for (int i = STAGES - 2; i >= 0; i--) begin
            all_above = all_above & valid_q[i+1];
            adv[i]    = valid_q[i] & ~freeze & (~all_above | out_xfer);
        end
        up.ready = ~rst & ~freeze & ~flush & (~valid_q[0] | adv[0]);
        in_xfer  = up.valid & up.ready;
    end

    // Next-state of every stage; flush kills after the advance is applied.
    always_comb begin
        src_data    = '0;
        load        = '0;
        valid_d     = '0;
        killed      = '0;
        occupancy_d = '0;
        src_data[0] = up.data;
        load[0]     = in_xfer;
        valid_d[0]  = in_xfer | (valid_q[0] & ~adv[0]);
        for (int i = 1; i < STAGES; i++) begin
            src_data[i] = data_q[i-1];
            load[i]     = adv[i-1];
            valid_d[i]  = adv[i-1] | (valid_q[i] & ~adv[i]);
        end
        if (flush) begin
            for (int i = 0; i < FLUSH_STAGES; i++) begin
                killed     = killed + OCC_W'(valid_d[i]);
                valid_d[i] = 1'b0;
            end
        end
        for (int i = 0; i < STAGES; i++) begin
            occupancy_d = occupancy_d + OCC_W'(valid_d[i]);
        end
        cnt_sum       = {1'b0, flush_count_q} + (CNT_WIDTH+1)'(killed);
        flush_count_d = cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        epc_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .valid_d (valid_d[g]),
            .load    (load[g]),
            .data_in (src_data[g]),
            .valid_q (valid_q[g]),
            .data_q  (data_q[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy_q   <= '0;
            flush_count_q <= '0;
        end else begin
            occupancy_q   <= occupancy_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign occupancy   = occupancy_q;
    assign flush_count = flush_count_q;
endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Scenario bench for elastic_pipe_chain: a negedge monitor keeps an in-order
// scoreboard of accepted inputs; each task adds its own timing/state checks.
module tb_elastic_pipe_chain;
    localparam int DW = 32;
    localparam int ST = 4;
    localparam int FS = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          freeze = 1'b0;
    logic          flush = 1'b0;
    logic [2:0]    occupancy;
    logic [CW-1:0] flush_count;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    logic [DW-1:0] sb[$];

    elastic_pipe_chain_if #(.DATA_WIDTH(DW)) up_if ();
    elastic_pipe_chain_if #(.DATA_WIDTH(DW)) dn_if ();

    elastic_pipe_chain #(
        .DATA_WIDTH(DW), .STAGES(ST), .FLUSH_STAGES(FS), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .up(up_if), .dn(dn_if),
        .freeze(freeze), .flush(flush),
        .occupancy(occupancy), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Inputs are stable at negedge, so a handshake seen here completes at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (dn_if.valid && dn_if.ready) begin
                logic [DW-1:0] exp_d;
                n_cmp++;
                n_out++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL out_order: got unexpected %0h, want no output", dn_if.data);
                end else begin
                    exp_d = sb.pop_front();
                    if (dn_if.data !== exp_d) begin
                        n_bad++;
                        $display("FAIL out_order: got %0h want %0h", dn_if.data, exp_d);
                    end
                end
            end
            if (up_if.valid && up_if.ready) sb.push_back(up_if.data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        up_if.valid = 1'b0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic fill4(input logic [DW-1:0] base);
        dn_if.ready = 1'b0;
        for (int v = 0; v < 4; v++) begin
            up_if.valid = 1'b1;
            up_if.data  = base + DW'(v);
            tick();
        end
        up_if.valid = 1'b0;
    endtask

    task automatic test_reset();
        up_if.valid = 1'b1;
        up_if.data  = 32'h0;
        dn_if.ready = 1'b1;
        #2;
        n_cmp++; if (dn_if.valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b want 0", dn_if.valid); end
        n_cmp++; if (up_if.ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %0b want 0", up_if.ready); end
        n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
        n_cmp++; if (flush_count !== 16'd0) begin n_bad++; $display("FAIL rst_fcnt: got %0d want 0", flush_count); end
        n_cmp++; if (dn_if.data !== 32'h0) begin n_bad++; $display("FAIL rst_out_data: got %0h want 0", dn_if.data); end
    endtask

    task automatic test_single();
        int exp_occ[5] = '{1, 1, 1, 1, 0};
        int exp_v[5]   = '{0, 0, 0, 1, 0};
        do_reset();
        dn_if.ready = 1'b1;
        up_if.valid = 1'b1;
        up_if.data  = 32'hA5;
        tick();
        up_if.valid = 1'b0;
        for (int e = 0; e < 5; e++) begin
            n_cmp++; if (occupancy !== 3'(exp_occ[e])) begin n_bad++; $display("FAIL single_occ[%0d]: got %0d want %0d", e, occupancy, exp_occ[e]); end
            n_cmp++; if (dn_if.valid !== 1'(exp_v[e])) begin n_bad++; $display("FAIL single_valid[%0d]: got %0b want %0d", e, dn_if.valid, exp_v[e]); end
            if (e == 3) begin
                n_cmp++; if (dn_if.data !== 32'hA5) begin n_bad++; $display("FAIL single_data: got %0h want a5", dn_if.data); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int idx = 1;
        int base;
        do_reset();
        dn_if.ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            up_if.valid = 1'b1;
            up_if.data  = DW'(idx);
            #1;
            if (!up_if.ready) break;
            idx++;
            tick();
        end
        n_cmp++; if (idx - 1 != 4) begin n_bad++; $display("FAIL bp_accepts: got %0d want 4", idx - 1); end
        n_cmp++; if (occupancy !== 3'd4) begin n_bad++; $display("FAIL bp_occ_full: got %0d want 4", occupancy); end
        n_cmp++; if (up_if.ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %0b want 0", up_if.ready); end
        base = n_out;
        dn_if.ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (idx <= 8) begin
                up_if.valid = 1'b1;
                up_if.data  = DW'(idx);
            end else up_if.valid = 1'b0;
            #1;
            n_cmp++; if (dn_if.valid !== 1'b1) begin n_bad++; $display("FAIL bp_stream_valid[%0d]: got %0b want 1", k, dn_if.valid); end
            if (up_if.valid && up_if.ready) idx++;
            tick();
        end
        up_if.valid = 1'b0;
        n_cmp++; if (n_out - base != 8) begin n_bad++; $display("FAIL bp_out_count: got %0d want 8", n_out - base); end
        n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL bp_occ_empty: got %0d want 0", occupancy); end
    endtask

    task automatic test_bubble();
        do_reset();
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 32'h11;
        tick();
        up_if.valid = 1'b0;
        repeat (3) tick();
        up_if.valid = 1'b1;
        up_if.data  = 32'h22;
        tick();
        up_if.valid = 1'b0;
        repeat (2) tick();
        n_cmp++; if (occupancy !== 3'd2) begin n_bad++; $display("FAIL bub_occ: got %0d want 2", occupancy); end
        n_cmp++; if (dn_if.data !== 32'h11) begin n_bad++; $display("FAIL bub_head: got %0h want 11", dn_if.data); end
        n_cmp++; if (up_if.ready !== 1'b1) begin n_bad++; $display("FAIL bub_in_ready: got %0b want 1", up_if.ready); end
        dn_if.ready = 1'b1;
        tick();
        n_cmp++; if (dn_if.valid !== 1'b1 || dn_if.data !== 32'h22) begin n_bad++; $display("FAIL bub_next: got v=%0b d=%0h want v=1 d=22", dn_if.valid, dn_if.data); end
        tick();
        n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL bub_drain: got %0d want 0", occupancy); end
    endtask

    task automatic test_flush();
        int base;
        do_reset();
        fill4(32'h1);
        n_cmp++; if (occupancy !== 3'd4) begin n_bad++; $display("FAIL fl_occ_full: got %0d want 4", occupancy); end
        flush = 1'b1;
        // The two youngest entries sit in the flushed stages.
        void'(sb.pop_back());
        void'(sb.pop_back());
        #1;
        n_cmp++; if (up_if.ready !== 1'b0) begin n_bad++; $display("FAIL fl_in_ready: got %0b want 0", up_if.ready); end
        tick();
        flush = 1'b0;
        n_cmp++; if (occupancy !== 3'd2) begin n_bad++; $display("FAIL fl_occ: got %0d want 2", occupancy); end
        n_cmp++; if (flush_count !== 16'd2) begin n_bad++; $display("FAIL fl_count: got %0d want 2", flush_count); end
        base = n_out;
        dn_if.ready = 1'b1;
        repeat (6) tick();
        n_cmp++; if (n_out - base != 2) begin n_bad++; $display("FAIL fl_out_count: got %0d want 2", n_out - base); end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL fl_sb_left: got %0d want 0", sb.size()); end
    endtask

    task automatic test_freeze();
        int idx = 32'h55;
        do_reset();
        fill4(32'h51);
        freeze = 1'b1;
        dn_if.ready = 1'b1;
        up_if.valid = 1'b1;
        up_if.data  = 32'h55;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (dn_if.valid !== 1'b0) begin n_bad++; $display("FAIL frz_out_valid[%0d]: got %0b want 0", c, dn_if.valid); end
            n_cmp++; if (up_if.ready !== 1'b0) begin n_bad++; $display("FAIL frz_in_ready[%0d]: got %0b want 0", c, up_if.ready); end
            n_cmp++; if (occupancy !== 3'd4) begin n_bad++; $display("FAIL frz_occ[%0d]: got %0d want 4", c, occupancy); end
            tick();
        end
        freeze = 1'b0;
        #1;
        n_cmp++; if (dn_if.valid !== 1'b1 || dn_if.data !== 32'h51) begin n_bad++; $display("FAIL frz_resume: got v=%0b d=%0h want v=1 d=51", dn_if.valid, dn_if.data); end
        for (int c = 0; c < 12; c++) begin
            if (idx <= 32'h57) begin
                up_if.valid = 1'b1;
                up_if.data  = DW'(idx);
            end else up_if.valid = 1'b0;
            #1;
            if (up_if.valid && up_if.ready) idx++;
            tick();
        end
        up_if.valid = 1'b0;
        n_cmp++; if (sb.size() != 0 || occupancy !== 3'd0) begin n_bad++; $display("FAIL frz_drain: got sb=%0d occ=%0d want 0/0", sb.size(), occupancy); end
    endtask

    task automatic test_async_reset();
        do_reset();
        dn_if.ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            up_if.valid = 1'b1;
            up_if.data  = 32'h60 + DW'(c);
            tick();
        end
        // Full streaming chain: only the entry in stage 0 survives the advance into a flushed stage.
        flush = 1'b1;
        void'(sb.pop_back());
        tick();
        flush = 1'b0;
        n_cmp++; if (flush_count !== 16'd1) begin n_bad++; $display("FAIL ar_fcnt: got %0d want 1", flush_count); end
        n_cmp++; if (occupancy !== 3'd2) begin n_bad++; $display("FAIL ar_occ_flush: got %0d want 2", occupancy); end
        up_if.data = 32'h70;
        tick();
        up_if.data = 32'h71;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (dn_if.valid !== 1'b0) begin n_bad++; $display("FAIL ar_out_valid: got %0b want 0", dn_if.valid); end
        n_cmp++; if (occupancy !== 3'd0) begin n_bad++; $display("FAIL ar_occ: got %0d want 0", occupancy); end
        n_cmp++; if (flush_count !== 16'd0) begin n_bad++; $display("FAIL ar_fcnt_rst: got %0d want 0", flush_count); end
        n_cmp++; if (up_if.ready !== 1'b0) begin n_bad++; $display("FAIL ar_in_ready: got %0b want 0", up_if.ready); end
        sb.delete();
        up_if.valid = 1'b0;
        tick();
        rst = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 32'h66;
        tick();
        up_if.valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (dn_if.valid !== 1'b0) begin n_bad++; $display("FAIL ar_early: got %0b want 0", dn_if.valid); end
        tick();
        n_cmp++; if (dn_if.valid !== 1'b1 || dn_if.data !== 32'h66) begin n_bad++; $display("FAIL ar_first: got v=%0b d=%0h want v=1 d=66", dn_if.valid, dn_if.data); end
        tick();
        n_cmp++; if (sb.size() != 0 || occupancy !== 3'd0) begin n_bad++; $display("FAIL ar_drain: got sb=%0d occ=%0d want 0/0", sb.size(), occupancy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_bubble();
        test_flush();
        test_freeze();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
